// File: rtl/axi_stream_pattern_generator_pkg.sv
// Shared constants and types for the AXI-Stream pattern generator.
// Register offsets, control bit positions, mode and state encodings.
package axi_stream_pattern_generator_pkg;

  localparam logic [7:0] REG_CTRL    = 8'h00;
  localparam logic [7:0] REG_STATUS  = 8'h04;
  localparam logic [7:0] REG_VALUE   = 8'h08;
  localparam logic [7:0] REG_STEP    = 8'h0C;
  localparam logic [7:0] REG_CNT_LO  = 8'h10;
  localparam logic [7:0] REG_CNT_HI  = 8'h14;
  localparam logic [7:0] REG_PKT_LEN = 8'h18;
  localparam logic [7:0] REG_SENT    = 8'h1C;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_MODE  = 4;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_WALK  = 2'd2
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] apply_strb(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/axi_stream_pattern_generator_regs.sv
// AXI4-Lite handshake front end: turns bus transactions into
// single-cycle register write and read strobes.
module axi_lite_slave_regs #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          reset,
  input  logic [AW-1:0] s_axi_awaddr,
  input  logic          s_axi_awvalid,
  output logic          s_axi_awready,
  input  logic [DW-1:0] s_axi_wdata,
  input  logic [3:0]    s_axi_wstrb,
  input  logic          s_axi_wvalid,
  output logic          s_axi_wready,
  output logic [1:0]    s_axi_bresp,
  output logic          s_axi_bvalid,
  input  logic          s_axi_bready,
  input  logic [AW-1:0] s_axi_araddr,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  output logic [DW-1:0] s_axi_rdata,
  output logic [1:0]    s_axi_rresp,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [3:0]    wr_strb,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data
);

  logic          r_bvalid;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          w_wr_hs;
  logic          w_rd_hs;

  assign w_wr_hs = s_axi_awvalid & s_axi_wvalid & ~r_bvalid;
  assign w_rd_hs = s_axi_arvalid & ~r_rvalid;

  assign s_axi_awready = w_wr_hs;
  assign s_axi_wready  = w_wr_hs;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = w_rd_hs;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;

  assign wr_en   = w_wr_hs;
  assign wr_addr = s_axi_awaddr;
  assign wr_data = s_axi_wdata;
  assign wr_strb = s_axi_wstrb;
  assign rd_en   = w_rd_hs;
  assign rd_addr = s_axi_araddr;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_wr_hs)           r_bvalid <= 1'b1;
      else if (s_axi_bready) r_bvalid <= 1'b0;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= rd_data;
      end else if (s_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_stream_pattern_generator.sv
// AXI-Stream pattern source (constant / ramp / walking-one) with
// finite or endless beat count and periodic tlast framing.
module axi_stream_pattern_generator
  import axi_stream_pattern_generator_pkg::*;
#(
  parameter int C_DATA_OUT_DATA_WIDTH = 8,
  parameter int C_S_AXI_DATA_WIDTH    = 32,
  parameter int C_S_AXI_ADDR_WIDTH    = 5,
  parameter int C_COUNT_WIDTH         = 41
) (
  input  logic                          aclk,
  input  logic                          reset,
  output logic                          data_out_tvalid,
  output logic [C_DATA_OUT_DATA_WIDTH-1:0] data_out_tdata,
  output logic                          data_out_tlast,
  input  logic                          data_out_tready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int W   = C_DATA_OUT_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int CW  = C_COUNT_WIDTH;
  localparam logic [31:0] HI_MASK =
    32'((64'd1 << (CW - 32)) - 64'd1);

  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [31:0]   w_wr_data;
  logic [3:0]    w_wr_strb;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [31:0]   w_rd_data;

  axi_lite_slave_regs #(.AW(AW), .DW(32)) u_regs (
    .aclk(aclk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .wr_strb(w_wr_strb), .rd_en(w_rd_en), .rd_addr(w_rd_addr),
    .rd_data(w_rd_data)
  );

  logic [1:0]    r_mode;
  logic [31:0]   r_value;
  logic [31:0]   r_step;
  logic [31:0]   r_cnt_lo;
  logic [31:0]   r_cnt_hi;
  logic [31:0]   r_pkt_len;

  state_e        r_state;
  state_e        w_state_next;
  logic [1:0]    r_mode_s;
  logic [W-1:0]  r_step_s;
  logic [31:0]   r_pkt_s;
  logic [CW-1:0] r_remaining;
  logic          r_inf;
  logic [31:0]   r_beat;
  logic [31:0]   r_sent;
  logic [W-1:0]  r_tdata;
  logic          r_stop_pend;

  logic [7:0]    w_wa;
  logic [7:0]    w_ra;
  logic          w_wr_ctrl;
  logic          w_start;
  logic          w_stop;
  logic [1:0]    w_mode_new;
  logic          w_capture;
  logic          w_hs;
  logic          w_final;
  logic          w_tlast;

  assign w_wa = 8'(w_wr_addr);
  assign w_ra = 8'(w_rd_addr);

  assign w_wr_ctrl  = w_wr_en && (w_wa == REG_CTRL) && w_wr_strb[0];
  assign w_start    = w_wr_ctrl && w_wr_data[CTRL_START];
  assign w_stop     = w_wr_ctrl && w_wr_data[CTRL_STOP];
  assign w_mode_new = w_wr_ctrl ?
                      w_wr_data[CTRL_MODE +: 2] : r_mode;

  assign w_hs      = (r_state == RUN) && data_out_tready;
  assign w_final   = !r_inf && (r_remaining == CW'(1));
  assign w_capture = (r_state == IDLE) && w_start;
  assign w_tlast   = (r_state == RUN) &&
                     (((r_pkt_s != '0) &&
                       (r_beat == r_pkt_s - 32'd1)) || w_final);

  assign data_out_tvalid = (r_state == RUN);
  assign data_out_tdata  = r_tdata;
  assign data_out_tlast  = w_tlast;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_state_next = RUN;
      RUN:  if (w_hs && (w_final || r_stop_pend))
              w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Config registers are free to change while running; only the
  // shadow copies taken at START drive the datapath.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_mode    <= '0;
      r_value   <= '0;
      r_step    <= '0;
      r_cnt_lo  <= '0;
      r_cnt_hi  <= '0;
      r_pkt_len <= '0;
    end else if (w_wr_en) begin
      unique case (w_wa)
        REG_CTRL:    if (w_wr_strb[0])
                       r_mode <= w_wr_data[CTRL_MODE +: 2];
        REG_VALUE:   r_value <=
                       apply_strb(r_value, w_wr_data, w_wr_strb);
        REG_STEP:    r_step <=
                       apply_strb(r_step, w_wr_data, w_wr_strb);
        REG_CNT_LO:  r_cnt_lo <=
                       apply_strb(r_cnt_lo, w_wr_data, w_wr_strb);
        REG_CNT_HI:  r_cnt_hi <= HI_MASK &
                       apply_strb(r_cnt_hi, w_wr_data, w_wr_strb);
        REG_PKT_LEN: r_pkt_len <=
                       apply_strb(r_pkt_len, w_wr_data, w_wr_strb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_mode_s    <= '0;
      r_step_s    <= '0;
      r_pkt_s     <= '0;
      r_remaining <= '0;
      r_inf       <= 1'b0;
      r_beat      <= '0;
      r_sent      <= '0;
      r_tdata     <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      r_stop_pend <= (w_state_next == RUN) &&
                     (r_stop_pend || ((r_state == RUN) && w_stop));
      if (w_capture) begin
        r_mode_s    <= w_mode_new;
        r_step_s    <= r_step[W-1:0];
        r_pkt_s     <= r_pkt_len;
        r_remaining <= CW'({r_cnt_hi, r_cnt_lo});
        r_inf       <= ({r_cnt_hi, r_cnt_lo} == 64'd0);
        r_beat      <= '0;
        r_sent      <= '0;
        r_tdata     <= (w_mode_new == MODE_WALK) ?
                       W'(1) : r_value[W-1:0];
      end else if (w_hs) begin
        unique case (1'b1)
          (r_mode_s == MODE_RAMP): r_tdata <= r_tdata + r_step_s;
          (r_mode_s == MODE_WALK): r_tdata <=
            (r_tdata << 1) | (r_tdata >> (W - 1));
          default: r_tdata <= r_tdata;
        endcase
        r_sent <= r_sent + 32'd1;
        if (!r_inf) r_remaining <= r_remaining - CW'(1);
        r_beat <= w_tlast ? '0 : r_beat + 32'd1;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd_en) begin
      unique case (w_ra)
        REG_CTRL:    w_rd_data[CTRL_MODE +: 2] = r_mode;
        REG_STATUS:  w_rd_data[1:0] =
                       {r_stop_pend, r_state == RUN};
        REG_VALUE:   w_rd_data = r_value;
        REG_STEP:    w_rd_data = r_step;
        REG_CNT_LO:  w_rd_data = r_cnt_lo;
        REG_CNT_HI:  w_rd_data = r_cnt_hi;
        REG_PKT_LEN: w_rd_data = r_pkt_len;
        REG_SENT:    w_rd_data = r_sent;
        default:     w_rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_pattern_generator.sv
// Directed self-checking bench for axi_stream_pattern_generator.
// One task per scenario, run in sequence from a single initial block.
module tb_axi_stream_pattern_generator;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        tvalid;
  logic [7:0]  tdata;
  logic        tlast;
  logic        tready = 1'b0;
  logic [4:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [4:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_stream_pattern_generator dut (
    .aclk(aclk), .reset(reset),
    .data_out_tvalid(tvalid), .data_out_tdata(tdata),
    .data_out_tlast(tlast), .data_out_tready(tready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready)
  );

  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s = 4'hF);
    bit ok = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (awready && wready) begin ok = 1; break; end
    end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL axi_wr_timeout addr=%h", a);
    end
  endtask

  task automatic axi_rd(input logic [4:0] a, output logic [31:0] d,
                        output logic [1:0] r);
    bit ok = 0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (arready) begin ok = 1; break; end
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    d = rdata; r = rresp;
    checks++;
    if (!ok || !rvalid) begin
      failures++;
      $display("FAIL axi_rd_handshake addr=%h rvalid=%b", a, rvalid);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [4:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_rd(a, d, r);
    checks++;
    if (d !== exp || r !== 2'b00) begin
      failures++;
      $display("FAIL %s got=%h/%b want=%h/00", nm, d, r, exp);
    end
  endtask

  task automatic one_beat_stop();
    tready = 1'b1;
    @(posedge aclk); #1;
    tready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++;
    if ({tvalid, tdata, tlast, awready, bvalid, arready, rvalid}
        !== 13'b0) begin
      failures++;
      $display("FAIL reset_outputs got tv=%b td=%h tl=%b want 0",
               tvalid, tdata, tlast);
    end
    @(negedge aclk); reset = 1'b0;
    chk_rd("reset_status", 5'h04, 32'h0);
    chk_rd("reset_value", 5'h08, 32'h0);
  endtask

  task automatic test_axi();
    axi_wr(5'h08, 32'h11223344);
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL bresp got=%b/%b want=1/00", bvalid, bresp);
    end
    axi_wr(5'h08, 32'hAABBCCDD, 4'b0001);
    chk_rd("wstrb_byte0", 5'h08, 32'h112233DD);
    chk_rd("unmapped_rd", 5'h02, 32'h0);
    axi_wr(5'h02, 32'hFFFFFFFF);
    chk_rd("unmapped_wr_ignored", 5'h00, 32'h0);
  endtask

  task automatic test_ramp();
    logic [7:0] exp_d [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    axi_wr(5'h08, 32'hFE);
    axi_wr(5'h0C, 32'h1);
    axi_wr(5'h10, 32'h4);
    axi_wr(5'h18, 32'h0);
    tready = 1'b1;
    axi_wr(5'h00, 32'h11);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== exp_d[i] ||
          tlast !== (i == 3)) begin
        failures++;
        $display("FAIL ramp_beat%0d got=%b/%h/%b want=1/%h/%b",
                 i, tvalid, tdata, tlast, exp_d[i], i == 3);
      end
    end
    @(negedge aclk);
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL ramp_end got tv=%b tl=%b want 0/0",
               tvalid, tlast);
    end
    tready = 1'b0;
    chk_rd("ramp_sent", 5'h1C, 32'd4);
    chk_rd("ramp_status", 5'h04, 32'd0);
  endtask

  task automatic test_const_stall();
    int nb = 0;
    bit pst = 0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    axi_wr(5'h08, 32'h5A);
    axi_wr(5'h10, 32'h6);
    axi_wr(5'h18, 32'h3);
    tready = 1'b0;
    axi_wr(5'h00, 32'h01);
    for (int c = 0; c < 40 && nb < 6; c++) begin
      @(negedge aclk);
      tready = ~tready;
      if (pst) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
          failures++;
          $display("FAIL const_stall got=%b/%h/%b want=1/%h/%b",
                   tvalid, tdata, tlast, pd, pl);
        end
      end
      if (tvalid && tready) begin
        checks++;
        if (tdata !== 8'h5A || tlast !== (nb == 2 || nb == 5)) begin
          failures++;
          $display("FAIL const_beat%0d got=%h/%b want=5a/%b",
                   nb, tdata, tlast, nb == 2 || nb == 5);
        end
        nb++;
      end
      pst = tvalid && !tready;
      pd = tdata; pl = tlast;
    end
    checks++;
    if (nb != 6) begin
      failures++;
      $display("FAIL const_count got=%0d want=6", nb);
    end
    @(negedge aclk);
    tready = 1'b0;
    checks++;
    if (tvalid !== 1'b0) begin
      failures++;
      $display("FAIL const_end got tv=%b want 0", tvalid);
    end
  endtask

  task automatic test_walk_stop();
    logic [7:0] e;
    axi_wr(5'h10, 32'h0);
    axi_wr(5'h14, 32'h0);
    axi_wr(5'h18, 32'h0);
    tready = 1'b1;
    axi_wr(5'h00, 32'h21);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      e = 8'h01 << (i % 8);
      checks++;
      if (tvalid !== 1'b1 || tdata !== e || tlast !== 1'b0) begin
        failures++;
        $display("FAIL walk_beat%0d got=%b/%h/%b want=1/%h/0",
                 i, tvalid, tdata, tlast, e);
      end
    end
    @(posedge aclk); #1;
    tready = 1'b0;
    axi_wr(5'h00, 32'h22);
    chk_rd("walk_stop_pending", 5'h04, 32'h3);
    @(negedge aclk);
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h04 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL walk_held got=%b/%h/%b want=1/04/0",
               tvalid, tdata, tlast);
    end
    one_beat_stop();
    checks++;
    if (tvalid !== 1'b0) begin
      failures++;
      $display("FAIL walk_stopped got tv=%b want 0", tvalid);
    end
    chk_rd("walk_status_idle", 5'h04, 32'h0);
    chk_rd("walk_sent", 5'h1C, 32'd11);
  endtask

  task automatic test_config_change();
    axi_wr(5'h08, 32'h11);
    tready = 1'b0;
    axi_wr(5'h00, 32'h01);
    tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 tready = 1'b0;
    axi_wr(5'h08, 32'h33);
    axi_wr(5'h00, 32'h01);
    chk_rd("cfg_sent_kept", 5'h1C, 32'd3);
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h11) begin
      failures++;
      $display("FAIL cfg_unaffected got=%b/%h want=1/11",
               tvalid, tdata);
    end
    tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1 tready = 1'b0;
    chk_rd("cfg_sent_more", 5'h1C, 32'd5);
    axi_wr(5'h00, 32'h02);
    one_beat_stop();
    axi_wr(5'h00, 32'h01);
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h33) begin
      failures++;
      $display("FAIL cfg_new_start got=%b/%h want=1/33",
               tvalid, tdata);
    end
    axi_wr(5'h00, 32'h02);
    one_beat_stop();
  endtask

  task automatic test_boundaries();
    axi_wr(5'h08, 32'h0);
    axi_wr(5'h0C, 32'h1);
    axi_wr(5'h10, 32'h1);
    axi_wr(5'h14, 32'h1);
    chk_rd("count_hi_rd", 5'h14, 32'h1);
    tready = 1'b0;
    axi_wr(5'h00, 32'h11);
    tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b1 || tdata !== 8'(i) || tlast !== 1'b0) begin
        failures++;
        $display("FAIL big_count_beat%0d got=%b/%h/%b want=1/%h/0",
                 i, tvalid, tdata, tlast, 8'(i));
      end
    end
    @(posedge aclk); #1;
    tready = 1'b0;
    chk_rd("big_count_busy", 5'h04, 32'h1);
    axi_wr(5'h00, 32'h02);
    one_beat_stop();
    axi_wr(5'h14, 32'h0);
    axi_wr(5'h08, 32'h77);
    axi_wr(5'h00, 32'h01);
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'h77 || tlast !== 1'b1) begin
      failures++;
      $display("FAIL count1_beat got=%b/%h/%b want=1/77/1",
               tvalid, tdata, tlast);
    end
    one_beat_stop();
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL count1_end got=%b/%b want=0/0", tvalid, tlast);
    end
  endtask

  task automatic test_reset_mid();
    axi_wr(5'h08, 32'h42);
    axi_wr(5'h10, 32'h0);
    axi_wr(5'h18, 32'h5);
    tready = 1'b1;
    axi_wr(5'h00, 32'h01);
    repeat (2) @(posedge aclk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tvalid !== 1'b0 || tdata !== 8'h0 || tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%b/%h/%b want=0/00/0",
               tvalid, tdata, tlast);
    end
    tready = 1'b0;
    @(posedge aclk); #1 reset = 1'b0;
    chk_rd("reset_mid_value", 5'h08, 32'h0);
    chk_rd("reset_mid_pkt", 5'h18, 32'h0);
    chk_rd("reset_mid_sent", 5'h1C, 32'h0);
    chk_rd("reset_mid_status", 5'h04, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_axi();
    test_ramp();
    test_const_stall();
    test_walk_stop();
    test_config_change();
    test_boundaries();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
